// File: rtl/mod1_seq_detector.sv
// -----------------------------------------------------------------------------
// mod1_seq_detector
//
// Serial bit-sequence detector. The block samples one bit of x on every rising
// clock edge and raises z for one cycle when the last PAT_LEN samples equal
// PATTERN. Overlapping matches count, so a periodic pattern gives consecutive
// z pulses.
//
// The detector is a generic shift/compare:
//   - hist holds the previous PAT_LEN-1 samples.
//   - The current bit x is appended to hist to form the comparison window.
//   - fill counts valid samples since reset and saturates at PAT_LEN-1.
//     Because of fill, the zero-filled history left by reset can never fake a
//     match, even when PATTERN is all zeros.
//
// Parameters:
//   PAT_LEN   pattern length in bits, legal range 2..16
//   PATTERN   target sequence; MSB is the oldest bit, LSB the newest
//
// Ports:
//   clock      in   1   single clock; all logic is on its rising edge
//   reset      in   1   synchronous, active-high; clears all state
//   x          in   1   serial data bit, sampled on every rising edge
//   z          out  1   registered match pulse, with no comb path from x
//   match_cnt  out  8   saturating match count (present only with the
//                       optional feature below)
//
// Optional feature (compile-time macro):
//   MOD1_MATCH_CNT_EN  adds match_cnt[7:0]. It increments on every edge that
//                      sets z to 1, saturates at 255 and is cleared by reset.
//                      z behaves the same whether or not the macro is defined.
// -----------------------------------------------------------------------------
module mod1_seq_detector #(
  parameter int unsigned          PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       x,
  output logic       z
`ifdef MOD1_MATCH_CNT_EN
  ,
  output logic [7:0] match_cnt
`endif
);

  // fill runs from 0 to PAT_LEN-1, so $clog2(PAT_LEN) bits are enough.
  localparam int unsigned          FILL_W   = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(PAT_LEN - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               z_q,    z_d;

  // Comparison window: the stored history plus the bit sampled on this edge.
  logic [PAT_LEN-1:0] win;
  logic               full;
  logic               hit;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a value before any conditional logic. A path
    // that left one unassigned would infer a latch.
    win    = {hist_q, x};
    full   = (fill_q == FILL_MAX);
    hit    = full && (win == PATTERN);

    // A match does not clear the history, which is how overlapping matches work.
    hist_d = win[PAT_LEN-2:0];
    fill_d = full ? fill_q : fill_q + FILL_W'(1);
    z_d    = hit;
  end

  // ---------------------------------------------------------------------------
  // State register. Reset takes priority over a match pending in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments. All flops then
      // update from the values that existed before the edge, and simulation
      // gives the same result as the synthesised registers.
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= z_d;
    end
  end

  assign z = z_q;

`ifdef MOD1_MATCH_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating match counter. It counts the same condition that loads z with 1.
  // ---------------------------------------------------------------------------
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (hit && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mod1_seq_detector.sv
// -----------------------------------------------------------------------------
// tb_mod1_seq_detector
//
// Bench for mod1_seq_detector. Three instances share one clock and one set of
// inputs:
//   dut_a  PATTERN = 4'b1100 (default)
//   dut_b  PATTERN = 4'b1010 (overlapping matches)
//   dut_c  PATTERN = 4'b0000 (fill guard and saturation)
//
// Each table record gives reset and x for one clock edge, the z expected after
// that edge, the instance to check, and the expected match_cnt (-1 means do not
// check). A hand-written long run on dut_c then exercises saturation.
// -----------------------------------------------------------------------------
module tb_mod1_seq_detector;

  logic clock;
  logic reset;
  logic x;
  logic z_a, z_b, z_c;
`ifdef MOD1_MATCH_CNT_EN
  logic [7:0] cnt_a, cnt_b, cnt_c;
`endif

  int errors = 0;
  int checks = 0;

  localparam int DUT_A = 0;
  localparam int DUT_B = 1;
  localparam int DUT_C = 2;

  mod1_seq_detector dut_a (
    .clock(clock), .reset(reset), .x(x), .z(z_a)
`ifdef MOD1_MATCH_CNT_EN
    , .match_cnt(cnt_a)
`endif
  );

  mod1_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1010)) dut_b (
    .clock(clock), .reset(reset), .x(x), .z(z_b)
`ifdef MOD1_MATCH_CNT_EN
    , .match_cnt(cnt_b)
`endif
  );

  mod1_seq_detector #(.PAT_LEN(4), .PATTERN(4'b0000)) dut_c (
    .clock(clock), .reset(reset), .x(x), .z(z_c)
`ifdef MOD1_MATCH_CNT_EN
    , .match_cnt(cnt_c)
`endif
  );

  // 10 ns clock. Rising edges fall at 5, 15, 25 ns and so on.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic rst;
    logic xin;
    logic exp_z;
    int   sel;
    int   exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic r, input logic xi, input logic ez,
                                  input int sel, input int ec);
    vec_t v;
    v.rst     = r;
    v.xin     = xi;
    v.exp_z   = ez;
    v.sel     = sel;
    v.exp_cnt = ec;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] actual,
                       input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic get_z(input int sel);
    case (sel)
      DUT_A:   return z_a;
      DUT_B:   return z_b;
      default: return z_c;
    endcase
  endfunction

`ifdef MOD1_MATCH_CNT_EN
  function automatic logic [7:0] get_cnt(input int sel);
    case (sel)
      DUT_A:   return cnt_a;
      DUT_B:   return cnt_b;
      default: return cnt_c;
    endcase
  endfunction
`endif

  // Drive inputs on the falling edge, then sample 1 ns after the next rising edge.
  task automatic step(input logic r, input logic xi);
    @(negedge clock);
    reset = r;
    x     = xi;
    @(posedge clock);
    #1;
  endtask

  // Watchdog: the bench must always terminate.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    x     = 1'b1;

    // ---- dut_a (1100): reset held for 2 edges with x=1 ----
    add_vec(1, 1, 0, DUT_A, 0);
    add_vec(1, 1, 0, DUT_A, 0);
    // Stream 1,1,1,0,0,1,1,1,0,0,1,1,0,0,1. Matches land on samples 5, 10 and 14.
    add_vec(0, 1, 0, DUT_A, 0);
    add_vec(0, 1, 0, DUT_A, 0);
    add_vec(0, 1, 0, DUT_A, 0);
    add_vec(0, 0, 0, DUT_A, 0);
    add_vec(0, 0, 1, DUT_A, 1);
    add_vec(0, 1, 0, DUT_A, 1);
    add_vec(0, 1, 0, DUT_A, -1);
    add_vec(0, 1, 0, DUT_A, -1);
    add_vec(0, 0, 0, DUT_A, -1);
    add_vec(0, 0, 1, DUT_A, 2);
    add_vec(0, 1, 0, DUT_A, -1);
    add_vec(0, 1, 0, DUT_A, -1);
    add_vec(0, 0, 0, DUT_A, -1);
    add_vec(0, 0, 1, DUT_A, 3);
    add_vec(0, 1, 0, DUT_A, 3);
    // Mid-sequence reset: send 1,1,0, then reset with x=0. Without the reset,
    // that edge would complete 1100. Reset must win and discard the history.
    add_vec(0, 1, 0, DUT_A, -1);
    add_vec(0, 1, 0, DUT_A, -1);
    add_vec(0, 0, 0, DUT_A, 3);
    add_vec(1, 0, 0, DUT_A, 0);
    add_vec(0, 0, 0, DUT_A, 0);
    // After the reset, a fresh 1,1,0,0 matches on the fourth of those samples.
    add_vec(0, 1, 0, DUT_A, 0);
    add_vec(0, 1, 0, DUT_A, 0);
    add_vec(0, 0, 0, DUT_A, 0);
    add_vec(0, 0, 1, DUT_A, 1);

    // ---- dut_b (1010): overlapping matches after samples 4 and 6 ----
    add_vec(1, 0, 0, DUT_B, 0);
    add_vec(0, 1, 0, DUT_B, 0);
    add_vec(0, 0, 0, DUT_B, 0);
    add_vec(0, 1, 0, DUT_B, 0);
    add_vec(0, 0, 1, DUT_B, 1);
    add_vec(0, 1, 0, DUT_B, 1);
    add_vec(0, 0, 1, DUT_B, 2);

    // ---- dut_c (0000): fill guard. z first rises on the 4th sampled 0 ----
    add_vec(1, 0, 0, DUT_C, 0);
    add_vec(0, 0, 0, DUT_C, 0);
    add_vec(0, 0, 0, DUT_C, 0);
    add_vec(0, 0, 0, DUT_C, 0);
    add_vec(0, 0, 1, DUT_C, 1);
    add_vec(0, 0, 1, DUT_C, 2);
    add_vec(0, 0, 1, DUT_C, 3);
    add_vec(0, 1, 0, DUT_C, 3);
    add_vec(0, 0, 0, DUT_C, 3);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].xin);
      check($sformatf("vec%0d_z", i), 8'(get_z(vecs[i].sel)), 8'(vecs[i].exp_z));
`ifdef MOD1_MATCH_CNT_EN
      if (vecs[i].exp_cnt >= 0) begin
        check($sformatf("vec%0d_cnt", i), get_cnt(vecs[i].sel), 8'(vecs[i].exp_cnt));
      end
`endif
    end

    // ---- Saturation: 303 zeros into dut_c give 300 matches ----
    step(1'b1, 1'b0);
    check("sat_reset_z", 8'(z_c), 8'd0);
`ifdef MOD1_MATCH_CNT_EN
    check("sat_reset_cnt", cnt_c, 8'd0);
`endif
    for (int i = 1; i <= 303; i++) begin
      logic exp_z;
      int   exp_cnt;
      step(1'b0, 1'b0);
      exp_z   = (i >= 4);
      exp_cnt = (i < 4) ? 0 : ((i - 3 > 255) ? 255 : i - 3);
      check($sformatf("sat%0d_z", i), 8'(z_c), 8'(exp_z));
`ifdef MOD1_MATCH_CNT_EN
      check($sformatf("sat%0d_cnt", i), cnt_c, 8'(exp_cnt));
`endif
    end
    // A 1 breaks the run. The count holds at 255.
    step(1'b0, 1'b1);
    check("sat_break_z", 8'(z_c), 8'd0);
`ifdef MOD1_MATCH_CNT_EN
    check("sat_break_cnt", cnt_c, 8'd255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
